bcd_a_binario: RTL and testbench



---
 rtl/bcd_pkg.sv | 30 +++
 rtl/correccion_digito.sv | 16 +
 rtl/bcd_a_binario.sv | 118 +++++++++++
 tb/tb_bcd_a_binario.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// bcd_pkg : shared state encoding, digit-correction constants and sizing helper
// Rev 1.0
// ============================================================================
package bcd_pkg;

  typedef enum logic [1:0] {
    REPOSO       = 2'd0,
    CONVIRTIENDO = 2'd1,
    LISTO        = 2'd2
  } estado_t;

  localparam logic [3:0] UMBRAL = 4'd8;
  localparam logic [3:0] AJUSTE = 4'd3;

  // Smallest binary width able to hold 10^digitos - 1.
  function automatic int min_ancho_bin(input int digitos);
    longint unsigned potencia;
    int ancho;
    potencia = 1;
    for (int i = 0; i < digitos; i++) potencia = potencia * 10;
    ancho = 0;
    for (int b = 0; b < 63; b++)
      if ((64'd1 << b) < potencia) ancho = b + 1;
    return ancho;
  endfunction

endpackage
`default_nettype wire

// File: rtl/correccion_digito.sv
`default_nettype none
// ============================================================================
// correccion_digito : one reverse double-dabble step per digit (>= 8 -> -3)
// Rev 1.0
// ============================================================================
module correccion_digito
  import bcd_pkg::*;
(
  input  logic [3:0] digito_i,
  output logic [3:0] digito_o
);

  assign digito_o = (digito_i >= UMBRAL) ? (digito_i - AJUSTE) : digito_i;

endmodule
`default_nettype wire

// File: rtl/bcd_a_binario.sv
`default_nettype none
// ============================================================================
// bcd_a_binario : sequential BCD-to-binary converter, valid/ready both sides
// Optional digit range check: BCD_A_BINARIO_VALIDACION_EN.  Rev 1.0
// ============================================================================
module bcd_a_binario
  import bcd_pkg::*;
#(
  parameter int DIGITOS   = 4,
  parameter int ANCHO_BIN = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*DIGITOS-1:0]   entradaBCD,
  input  logic                   inValido,
  output logic                   inListo,
  output logic [ANCHO_BIN-1:0]   salidaBin,
  output logic                   errorBCD,
  output logic                   outValido,
  input  logic                   outAceptado
);

  localparam int ANCHO_BCD = 4 * DIGITOS;
  localparam int ANCHO_CNT = $clog2(ANCHO_BIN + 1);
  localparam logic [ANCHO_CNT-1:0] CUENTA_FIN = ANCHO_CNT'(ANCHO_BIN - 1);

  if (ANCHO_BIN < min_ancho_bin(DIGITOS)) begin : g_chk_ancho
    $error("bcd_a_binario: ANCHO_BIN too small for DIGITOS");
  end

  estado_t                estado_q, estado_d;
  logic [ANCHO_CNT-1:0]   cnt_q, cnt_d;
  logic [ANCHO_BCD-1:0]   bcd_q, bcd_d;
  logic [ANCHO_BIN-1:0]   bin_q, bin_d;
  logic                   error_q, error_d;

  logic [ANCHO_BCD+ANCHO_BIN-1:0] w_desp;
  logic [ANCHO_BCD-1:0]           w_bcd_corr;
  logic                           w_invalido;

  assign w_desp = {bcd_q, bin_q} >> 1;

  for (genvar g = 0; g < DIGITOS; g++) begin : g_digito
    correccion_digito u_corr (
      .digito_i (w_desp[ANCHO_BIN + 4*g +: 4]),
      .digito_o (w_bcd_corr[4*g +: 4])
    );
  end

`ifdef BCD_A_BINARIO_VALIDACION_EN
  always_comb begin
    w_invalido = 1'b0;
    for (int i = 0; i < DIGITOS; i++)
      if (entradaBCD[4*i +: 4] > 4'd9) w_invalido = 1'b1;
  end
`else
  assign w_invalido = 1'b0;
`endif

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    bin_d    = bin_q;
    error_d  = error_q;
    case (estado_q)
      REPOSO: begin
        if (inValido) begin
          bcd_d    = entradaBCD;
          bin_d    = '0;
          cnt_d    = '0;
          error_d  = w_invalido;
          estado_d = CONVIRTIENDO;
        end
      end
      CONVIRTIENDO: begin
        // An invalid word spends a single non-iterating cycle here so the
        // result appears one edge after capture with salidaBin still zero.
        if (error_q) begin
          bcd_d    = '0;
          estado_d = LISTO;
        end else begin
          bcd_d = w_bcd_corr;
          bin_d = w_desp[ANCHO_BIN-1:0];
          if (cnt_q == CUENTA_FIN) estado_d = LISTO;
          else                     cnt_d    = cnt_q + ANCHO_CNT'(1);
        end
      end
      LISTO: begin
        if (outAceptado) estado_d = REPOSO;
      end
      default: estado_d = REPOSO;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= REPOSO;
      cnt_q    <= '0;
      bcd_q    <= '0;
      bin_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      error_q  <= error_d;
    end
  end

  assign inListo   = (estado_q == REPOSO);
  assign outValido = (estado_q == LISTO);
  assign salidaBin = bin_q;
  assign errorBCD  = error_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_a_binario.sv
`default_nettype none
// ============================================================================
// tb_bcd_a_binario : directed vectors, scoreboard queue + decoupled monitor
// Rev 1.0
// ============================================================================
module tb_bcd_a_binario;

  localparam int DIGITOS   = 4;
  localparam int ANCHO_BIN = 14;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [4*DIGITOS-1:0] entradaBCD;
  logic                 inValido;
  logic                 inListo;
  logic [ANCHO_BIN-1:0] salidaBin;
  logic                 errorBCD;
  logic                 outValido;
  logic                 outAceptado;

  bcd_a_binario #(.DIGITOS(DIGITOS), .ANCHO_BIN(ANCHO_BIN)) dut (
    .clk         (clk),
    .reset       (reset),
    .entradaBCD  (entradaBCD),
    .inValido    (inValido),
    .inListo     (inListo),
    .salidaBin   (salidaBin),
    .errorBCD    (errorBCD),
    .outValido   (outValido),
    .outAceptado (outAceptado)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ANCHO_BIN-1:0] bin;
    logic                 err;
    logic                 chk_val;
    int                   lat;
    int                   t_cap;
  } item_t;

  item_t sb[$];
  item_t cur;
  bit    have_cur = 1'b0;
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nombre, input logic [31:0] actual,
                       input logic [31:0] esperado);
    n_checks++;
    if (actual === esperado) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  nombre, actual, esperado, cyc);
  endtask

  // Monitor: pops an expectation on each new result, re-checks it every
  // cycle it is held, and releases it once the consumer accepts.
  always @(negedge clk) begin
    if (!reset) begin
      if (!outValido && !have_cur && sb.size() != 0)
        check("inListo_low_converting", {31'd0, inListo}, 32'd0);
      if (outValido && !have_cur) begin
        if (sb.size() == 0) begin
          check("unexpected_output", {31'd0, outValido}, 32'd0);
        end else begin
          cur      = sb.pop_front();
          have_cur = 1'b1;
          check("latency", cyc - cur.t_cap, cur.lat);
        end
      end
      if (outValido && have_cur) begin
        if (cur.chk_val) check("salidaBin", {18'd0, salidaBin}, {18'd0, cur.bin});
        check("errorBCD", {31'd0, errorBCD}, {31'd0, cur.err});
        check("inListo_low_while_valid", {31'd0, inListo}, 32'd0);
        if (outAceptado) have_cur = 1'b0;
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!inListo && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!inListo) check("capture_timeout", {31'd0, inListo}, 32'd1);
  endtask

  task automatic send(input logic [15:0] w, input logic [ANCHO_BIN-1:0] eb,
                      input logic ee, input logic cv, input int lat);
    item_t it;
    @(posedge clk);
    #2;
    entradaBCD = w;
    inValido   = 1'b1;
    @(negedge clk);
    wait_ready();
    @(posedge clk);
    #1;
    it.bin = eb; it.err = ee; it.chk_val = cv; it.lat = lat; it.t_cap = cyc;
    sb.push_back(it);
    #1;
    inValido = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || have_cur) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0 || have_cur) check("drain_timeout", t, 32'd0);
    @(posedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_inListo"},   {31'd0, inListo},   32'd1);
    check({tag, "_outValido"}, {31'd0, outValido}, 32'd0);
    check({tag, "_salidaBin"}, {18'd0, salidaBin}, 32'd0);
    check({tag, "_errorBCD"},  {31'd0, errorBCD},  32'd0);
  endtask

  logic [15:0] vec_w   [3] = '{16'h1234, 16'h9999, 16'h0000};
  logic [13:0] vec_bin [3] = '{14'd1234, 14'd9999, 14'd0};

  initial begin
    reset       = 1'b0;
    inValido    = 1'b0;
    entradaBCD  = '0;
    outAceptado = 1'b1;
    #1 reset = 1'b1;
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back words, consumer always ready.
    for (int i = 0; i < 3; i++) send(vec_w[i], vec_bin[i], 1'b0, 1'b1, ANCHO_BIN);
    drain();

`ifdef BCD_A_BINARIO_VALIDACION_EN
    send(16'h12A4, 14'd0, 1'b1, 1'b1, 1);
`else
    send(16'h12A4, 14'd0, 1'b0, 1'b0, ANCHO_BIN);
`endif
    drain();

    // Backpressure: hold the result for six cycles.
    @(posedge clk);
    #2 outAceptado = 1'b0;
    send(16'h0042, 14'd42, 1'b0, 1'b1, ANCHO_BIN);
    begin
      int t = 0;
      while (!outValido && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!outValido) check("bp_wait_timeout", {31'd0, outValido}, 32'd1);
    end
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 outAceptado = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("inListo_after_accept", {31'd0, inListo}, 32'd1);
    drain();

    // Asynchronous reset during the 7th conversion cycle discards the word.
    @(posedge clk);
    #2;
    entradaBCD = 16'h5678;
    inValido   = 1'b1;
    @(negedge clk);
    wait_ready();
    @(posedge clk);
    #2 inValido = 1'b0;
    repeat (6) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_reset_vals("midconv_reset");
    @(negedge clk);
    reset = 1'b0;
    send(16'h0007, 14'd7, 1'b0, 1'b1, ANCHO_BIN);
    drain();

    // New words offered mid-conversion must be ignored.
    send(16'h1234, 14'd1234, 1'b0, 1'b1, ANCHO_BIN);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #2;
      inValido   = ~inValido;
      entradaBCD = 16'h9999;
    end
    @(posedge clk);
    #2 inValido = 1'b0;
    drain();

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
